// File: rtl/conv_sched.sv
// Sequencer driving one ConvAccum pass per input-channel group: weight fetch, gap,
// pixel stream, then wait for the accumulator's write-backs before the next group.
module conv_sched #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 16,
  parameter int KernelSize = 9,
  parameter int GapCycles  = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   start,
  input  logic [8:0]             row_in,
  input  logic [8:0]             col_in,
  input  logic [7:0]             num_groups,
  input  logic [AddrWidth-1:0]   weight_base,
  input  logic [AddrWidth-1:0]   data_base,
  output logic                   w_rd_en,
  output logic [AddrWidth-1:0]   w_rd_addr,
  input  logic [4*DataWidth-1:0] w_rd_data,
  output logic                   d_rd_en,
  output logic [AddrWidth-1:0]   d_rd_addr,
  input  logic [4*DataWidth-1:0] d_rd_data,
  output logic [4*DataWidth-1:0] weight_out,
  output logic                   weight_valid,
  output logic [4*DataWidth-1:0] data_out,
  output logic                   data_valid,
  output logic                   conv_first,
  output logic [8:0]             conv_row,
  output logic [8:0]             conv_col,
  input  logic                   wr_en_conv,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             group_idx
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_GAP, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [17:0] KLast = 18'(KernelSize - 1);
  localparam logic [17:0] GLast = 18'(GapCycles - 1);

  state_t               state_q, state_d;
  logic [8:0]           row_q, row_d, col_q, col_d;
  logic [7:0]           ng_q, ng_d, g_q, g_d;
  logic [17:0]          n_q, n_d, step_q, step_d, wcnt_q, wcnt_d, wcnt_sum;
  logic [AddrWidth-1:0] wptr_q, wptr_d, dptr_q, dptr_d;
  logic                 empty_q, empty_d, wv_q, wv_d, dv_q, dv_d, active;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ng_q    <= '0;
      g_q     <= '0;
      n_q     <= '0;
      step_q  <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      dptr_q  <= '0;
      empty_q <= 1'b0;
      wv_q    <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ng_q    <= ng_d;
      g_q     <= g_d;
      n_q     <= n_d;
      step_q  <= step_d;
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      dptr_q  <= dptr_d;
      empty_q <= empty_d;
      wv_q    <= wv_d;
      dv_q    <= dv_d;
    end
  end

  // Accumulator write-backs only count while this group's pixels are in flight.
  assign wcnt_sum = wcnt_q + {17'd0, wr_en_conv && (state_q == S_STREAM || state_q == S_DRAIN)};

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ng_d    = ng_q;
    g_d     = g_q;
    n_d     = n_q;
    step_d  = step_q;
    wcnt_d  = wcnt_sum;
    wptr_d  = wptr_q;
    dptr_d  = dptr_q;
    empty_d = empty_q;
    wv_d    = (state_q == S_LOAD_W);
    dv_d    = (state_q == S_STREAM);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = row_in;
          col_d   = col_in;
          ng_d    = num_groups;
          n_d     = 18'(row_in) * 18'(col_in);
          wptr_d  = weight_base;
          dptr_d  = data_base;
          g_d     = '0;
          step_d  = '0;
          wcnt_d  = '0;
          empty_d = (row_in == 9'd0) || (col_in == 9'd0) || (num_groups == 8'd0);
          // An empty job still spends one busy cycle so done lands two cycles after start.
          state_d = empty_d ? S_DRAIN : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (step_q == KLast) begin
          step_d  = '0;
          state_d = S_GAP;
        end else begin
          step_d = step_q + 18'd1;
        end
      end
      S_GAP: begin
        if (step_q == GLast) begin
          step_d  = '0;
          state_d = S_STREAM;
        end else begin
          step_d = step_q + 18'd1;
        end
      end
      S_STREAM: begin
        if (step_q == n_q - 18'd1) begin
          step_d  = '0;
          state_d = S_DRAIN;
        end else begin
          step_d = step_q + 18'd1;
        end
      end
      S_DRAIN: begin
        if (empty_q) begin
          state_d = S_DONE;
        end else if (wcnt_sum == n_q) begin
          if (({1'b0, g_q} + 9'd1) < {1'b0, ng_q}) begin
            g_d     = g_q + 8'd1;
            wcnt_d  = '0;
            wptr_d  = wptr_q + AddrWidth'(KernelSize);
            dptr_d  = dptr_q + AddrWidth'(n_q);
            state_d = S_LOAD_W;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active       = (state_q == S_LOAD_W) || (state_q == S_GAP) ||
                   (state_q == S_STREAM) || (state_q == S_DRAIN);
    w_rd_en      = (state_q == S_LOAD_W);
    d_rd_en      = (state_q == S_STREAM);
    w_rd_addr    = w_rd_en ? wptr_q + AddrWidth'(step_q) : '0;
    d_rd_addr    = d_rd_en ? dptr_q + AddrWidth'(step_q) : '0;
    weight_valid = wv_q;
    data_valid   = dv_q;
    weight_out   = wv_q ? w_rd_data : '0;
    data_out     = dv_q ? d_rd_data : '0;
    conv_first   = active && !empty_q && (g_q == 8'd0);
    conv_row     = row_q;
    conv_col     = col_q;
    busy         = active;
    done         = (state_q == S_DONE);
    group_idx    = g_q;
  end

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: expected reads and valid data are queued per run
// and matched as the sequencer issues them; a small ConvAccum model echoes data_valid.
module tb_conv_sched;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         start = 1'b0;
  logic [8:0]   row_in = '0, col_in = '0;
  logic [7:0]   num_groups = '0;
  logic [15:0]  weight_base = '0, data_base = '0;
  logic         w_rd_en, d_rd_en, weight_valid, data_valid, conv_first, busy, done;
  logic [15:0]  w_rd_addr, d_rd_addr;
  logic [127:0] w_rd_data = '0, d_rd_data = '0, weight_out, data_out;
  logic [8:0]   conv_row, conv_col;
  logic [7:0]   group_idx;
  logic         wr_en_conv;
  logic         auto_wr = 1'b1, manual_wr = 1'b0;
  logic [2:0]   dv_pipe = '0;

  typedef struct { int cyc; logic [15:0] addr; int grp; } rd_t;
  typedef struct { int cyc; logic [127:0] data; } vd_t;
  rd_t exp_w[$], exp_d[$];
  vd_t exp_wv[$], exp_dv[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, run_c0 = 0, run_done_cyc = 0;
  logic [8:0] run_row = '0, run_col = '0;
  bit track = 1'b0;

  conv_sched dut (
    .Clk(Clk), .Rst(Rst), .start(start), .row_in(row_in), .col_in(col_in),
    .num_groups(num_groups), .weight_base(weight_base), .data_base(data_base),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .d_rd_data(d_rd_data),
    .weight_out(weight_out), .weight_valid(weight_valid),
    .data_out(data_out), .data_valid(data_valid), .conv_first(conv_first),
    .conv_row(conv_row), .conv_col(conv_col), .wr_en_conv(wr_en_conv),
    .busy(busy), .done(done), .group_idx(group_idx)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [127:0] wmem(input logic [15:0] a);
    return {4{16'hA5C3, a}};
  endfunction
  function automatic logic [127:0] dmem(input logic [15:0] a);
    return {4{16'h3C5A, a ^ 16'h0F0F}};
  endfunction

  // Memories with one-cycle read latency.
  always @(posedge Clk) begin
    w_rd_data <= w_rd_en ? wmem(w_rd_addr) : 128'h0;
    d_rd_data <= d_rd_en ? dmem(d_rd_addr) : 128'h0;
  end

  // ConvAccum stand-in: one write-back two cycles after each valid pixel.
  always @(negedge Clk) dv_pipe <= {dv_pipe[1:0], data_valid};
  assign wr_en_conv = auto_wr ? dv_pipe[2] : manual_wr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  always @(negedge Clk) begin
    rd_t e;
    vd_t v;
    if (!Rst) begin
      if (w_rd_en) begin
        if (exp_w.size() == 0) check("w_extra", 128'(1), 128'(0));
        else begin
          e = exp_w.pop_front();
          check("w_cyc", 128'(cyc), 128'(e.cyc));
          check("w_addr", 128'(w_rd_addr), 128'(e.addr));
          check("w_grp", 128'({conv_first, group_idx}), 128'({e.grp == 0, 8'(e.grp)}));
          exp_wv.push_back('{e.cyc + 1, wmem(e.addr)});
        end
      end
      if (d_rd_en) begin
        if (exp_d.size() == 0) check("d_extra", 128'(1), 128'(0));
        else begin
          e = exp_d.pop_front();
          check("d_cyc", 128'(cyc), 128'(e.cyc));
          check("d_addr", 128'(d_rd_addr), 128'(e.addr));
          check("d_grp", 128'({conv_first, group_idx}), 128'({e.grp == 0, 8'(e.grp)}));
          check("conv_rc", 128'({conv_row, conv_col}), 128'({run_row, run_col}));
          exp_dv.push_back('{e.cyc + 1, dmem(e.addr)});
        end
      end
      if (weight_valid) begin
        if (exp_wv.size() == 0) check("wv_extra", 128'(1), 128'(0));
        else begin
          v = exp_wv.pop_front();
          check("wv_cyc", 128'(cyc), 128'(v.cyc));
          check("weight_out", weight_out, v.data);
        end
      end
      if (data_valid) begin
        if (exp_dv.size() == 0) check("dv_extra", 128'(1), 128'(0));
        else begin
          v = exp_dv.pop_front();
          check("dv_cyc", 128'(cyc), 128'(v.cyc));
          check("data_out", data_out, v.data);
        end
      end
      if (track) begin
        check("busy", 128'(busy), 128'(cyc > run_c0 && cyc < run_done_cyc));
        check("done", 128'(done), 128'(cyc == run_done_cyc));
      end
    end
  end

  // Drives a one-cycle start and queues every read and valid the job should produce.
  task automatic start_run(input int row, input int col, input int ng,
                           input logic [15:0] wb, input logic [15:0] db);
    int n, c0, gbase;
    start = 1'b1;
    row_in = 9'(row);
    col_in = 9'(col);
    num_groups = 8'(ng);
    weight_base = wb;
    data_base = db;
    c0 = cyc;
    n = row * col;
    run_row = 9'(row);
    run_col = 9'(col);
    if (row == 0 || col == 0 || ng == 0) begin
      run_done_cyc = c0 + 2;
    end else begin
      for (int g = 0; g < ng; g++) begin
        gbase = c0 + 1 + g * (n + 16);
        for (int k = 0; k < 9; k++) exp_w.push_back('{gbase + k, 16'(int'(wb) + g * 9 + k), g});
        for (int p = 0; p < n; p++) exp_d.push_back('{gbase + 13 + p, 16'(int'(db) + g * n + p), g});
      end
      run_done_cyc = c0 + 1 + ng * (n + 16);
    end
    run_c0 = c0;
    track = 1'b1;
    $display("run row=%0d col=%0d groups=%0d wbase=%0h dbase=%0h start_cycle=%0d done_expected=%0d",
             row, col, ng, wb, db, c0, run_done_cyc);
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_q();
    exp_w.delete();
    exp_d.delete();
    exp_wv.delete();
    exp_dv.delete();
  endtask

  task automatic finish_run();
    while (cyc < run_done_cyc + 2) tick(1);
    check("w_left", 128'(exp_w.size()), 128'(0));
    check("d_left", 128'(exp_d.size()), 128'(0));
    check("wv_left", 128'(exp_wv.size()), 128'(0));
    check("dv_left", 128'(exp_dv.size()), 128'(0));
    clear_q();
  endtask

  initial begin
    tick(3);
    check("rst_ctl", 128'({w_rd_en, d_rd_en, weight_valid, data_valid, conv_first, busy, done}), 128'(0));
    check("rst_idx", 128'({group_idx, conv_row, conv_col}), 128'(0));
    Rst = 1'b0;
    tick(2);

    start_run(6, 6, 1, 16'h0100, 16'h0200);
    finish_run();

    start_run(6, 6, 3, 16'h0100, 16'h0200);
    finish_run();

    start_run(2, 3, 2, 16'hFFFA, 16'hFFFD);
    finish_run();

    start_run(0, 6, 0, 16'h0100, 16'h0200);
    finish_run();

    // A second start in mid-stream must not disturb the running job.
    start_run(6, 6, 1, 16'h0300, 16'h0400);
    tick(19);
    start = 1'b1;
    row_in = 9'd3;
    col_in = 9'd2;
    num_groups = 8'd5;
    tick(1);
    start = 1'b0;
    finish_run();
    check("rc_hold", 128'({conv_row, conv_col}), 128'({9'd6, 9'd6}));

    // Abort at pixel 10 of group 1.
    start_run(6, 6, 3, 16'h0100, 16'h0200);
    tick(75);
    #2;
    track = 1'b0;
    Rst = 1'b1;
    #1;
    check("abort_ctl", 128'({w_rd_en, d_rd_en, weight_valid, data_valid, conv_first, busy, done}), 128'(0));
    check("abort_idx", 128'({w_rd_addr, d_rd_addr, group_idx, conv_row, conv_col}), 128'(0));
    check("abort_data", weight_out | data_out, 128'(0));
    clear_q();
    tick(2);
    Rst = 1'b0;
    run_c0 = cyc;
    run_done_cyc = -1;
    track = 1'b1;
    tick(10);
    start_run(4, 4, 1, 16'h0040, 16'h0080);
    finish_run();

    // Manual write-backs: IDLE strobes are ignored and DRAIN waits for all 16.
    auto_wr = 1'b0;
    repeat (5) begin
      manual_wr = 1'b1;
      tick(1);
      manual_wr = 1'b0;
      tick(1);
    end
    start_run(4, 4, 1, 16'h0010, 16'h0020);
    run_done_cyc = 32'h3FFF_FFFF;
    tick(45);
    check("drain_wait", 128'({busy, done}), 128'(2'b10));
    manual_wr = 1'b1;
    tick(15);
    manual_wr = 1'b0;
    tick(5);
    check("drain_hold", 128'({busy, done}), 128'(2'b10));
    manual_wr = 1'b1;
    run_done_cyc = cyc + 1;
    tick(1);
    manual_wr = 1'b0;
    finish_run();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
